// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: both cache-side access/ready ports plus the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic acc0, rd0, wr0, rdy0, err0;
  logic acc1, rd1, wr1, rdy1, err1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic mem_access, mem_read, mem_write, mem_ready, busy, grant_id;
  modport master (
    input  acc0, rd0, wr0, addr0, wdata0, acc1, rd1, wr1, addr1, wdata1, mem_ready, mem_rdata,
    output rdy0, rdata0, err0, rdy1, rdata1, err1, mem_access, mem_read, mem_write, mem_addr,
           mem_wdata, busy, grant_id
  );
  modport slave (
    output acc0, rd0, wr0, addr0, wdata0, acc1, rd1, wr1, addr1, wdata1, mem_ready, mem_rdata,
    input  rdy0, rdata0, err0, rdy1, rdata1, err1, mem_access, mem_read, mem_write, mem_addr,
           mem_wdata, busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin I$/D$ arbiter for one memory port; MEM_ARB_TIMEOUT_EN adds a BUSY timeout abort
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {NOP, READ, WRITE} op_t;
  state_t state, state_n;
  op_t op, sel_op;
  logic start, sel, win, last_grant, tmo, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  always_comb begin
    start = state == IDLE && (bus.acc0 || bus.acc1);
    sel = bus.acc0 && bus.acc1 ? !last_grant : bus.acc1;
    sel_op = (sel ? bus.wr1 : bus.wr0) ? WRITE : (sel ? bus.rd1 : bus.rd0) ? READ : NOP;
    state_n = state == RESP ? IDLE
            : state == BUSY ? ((bus.mem_ready || tmo) ? RESP : BUSY)
            : start ? (sel_op == NOP ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      win <= 1'b0;
      last_grant <= 1'b1;
      op <= NOP;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (start) begin
        win <= sel;
        op <= sel_op;
        addr_q <= sel ? bus.addr1 : bus.addr0;
        wdata_q <= sel ? bus.wdata1 : bus.wdata0;
      end
      if (state == BUSY && bus.mem_ready && op == READ && !win) rdata0_q <= bus.mem_rdata;
      if (state == BUSY && bus.mem_ready && op == READ && win) rdata1_q <= bus.mem_rdata;
      if (state == RESP) last_grant <= win;
    end
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt;
  // a mem_ready arriving on the final allowed cycle still completes normally
  assign tmo = state == BUSY && !bus.mem_ready && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      err_q <= tmo;
    end
`else
  logic unused_timeout;
  assign tmo = 1'b0;
  assign err_q = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif
  assign bus.busy = state != IDLE;
  assign bus.grant_id = win;
  assign bus.mem_access = state == BUSY;
  assign bus.mem_read = state == BUSY && op == READ;
  assign bus.mem_write = state == BUSY && op == WRITE;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdy0 = state == RESP && !win;
  assign bus.rdy1 = state == RESP && win;
  assign bus.err0 = state == RESP && !win && err_q;
  assign bus.err1 = state == RESP && win && err_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with response and memory-cycle scoreboards
module tb_mem_port_arbiter;
  typedef struct packed {logic port; logic err; logic [31:0] rdata;} rsp_t;
  typedef struct packed {logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata;} mem_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kick = 1'b0;
  logic prev_acc = 1'b0;
  logic [31:0] mem_data = '0;
  int checks = 0;
  int failures = 0;
  int bcnt = 0;
  int mem_lat = 0;
  rsp_t exp_q[$];
  mem_t mem_q[$];
  rsp_t r;
  mem_t m;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // memory model: ready in the mem_lat-th BUSY cycle, or whenever kick is set
  always @(negedge clk) begin
    bcnt = (bus.mem_access && !bus.mem_ready) ? bcnt + 1 : 0;
    bus.mem_ready = (bcnt != 0 && bcnt == mem_lat) || kick;
    bus.mem_rdata = bus.mem_ready ? mem_data : 32'h0;
  end

  always @(negedge clk) begin
    if (bus.mem_access && !prev_acc) begin
      if (mem_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected addr=0x%0h expected no memory cycle", bus.mem_addr);
      end else begin
        m = mem_q.pop_front();
        chk("mem_read", 64'(bus.mem_read), 64'(m.rd));
        chk("mem_write", 64'(bus.mem_write), 64'(m.wr));
        chk("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
      end
    end
    prev_acc = bus.mem_access;
  end

  always @(negedge clk) begin
    if ((bus.err0 && !bus.rdy0) || (bus.err1 && !bus.rdy1)) begin
      checks++;
      failures++;
      $display("FAIL err_without_rdy err0=%0d err1=%0d expected 0", bus.err0, bus.err1);
    end
    if (bus.rdy0 || bus.rdy1) begin
      if ((bus.rdy0 && bus.rdy1) || exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdy_unexpected rdy0=%0d rdy1=%0d queued=%0d", bus.rdy0, bus.rdy1, exp_q.size());
      end else begin
        r = exp_q.pop_front();
        chk("rdy_port", 64'(bus.rdy1), 64'(r.port));
        chk("grant_id", 64'(bus.grant_id), 64'(r.port));
        chk("rdata", 64'(bus.rdy1 ? bus.rdata1 : bus.rdata0), 64'(r.rdata));
        chk("err", 64'(bus.rdy1 ? bus.err1 : bus.err0), 64'(r.err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input bit p, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.acc1 = 1'b1; bus.rd1 = rd; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.acc0 = 1'b1; bus.rd0 = rd; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  // counts edges until rdy, drops acc in the rdy cycle, then lets the arbiter return to IDLE
  task automatic wait_rdy(input bit p, input int exp_edges);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(p ? bus.rdy1 : bus.rdy0) && n < 50);
    chk(p ? "latency1" : "latency0", 64'(n), 64'(exp_edges));
    if (p) bus.acc1 = 1'b0;
    else bus.acc0 = 1'b0;
    tick(1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.acc0 = 1'b0;
    bus.acc1 = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.acc0 = 0; bus.rd0 = 0; bus.wr0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.acc1 = 0; bus.rd1 = 0; bus.wr1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    tick(2);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_grant_id", 64'(bus.grant_id), 64'(0));
    chk("rst_mem_access", 64'(bus.mem_access), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_rdy", 64'({bus.rdy1, bus.rdy0, bus.err1, bus.err0}), 64'(0));
    chk("rst_rdata0", 64'(bus.rdata0), 64'(0));
    chk("rst_rdata1", 64'(bus.rdata1), 64'(0));
    // port0 read, memory answers in the 2nd BUSY cycle
    mem_lat = 2;
    mem_data = 32'hDEADBEEF;
    mem_q.push_back('{1'b1, 1'b0, 32'h100, 32'h0});
    exp_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    req(0, 1, 0, 32'h100, 32'h0);
    wait_rdy(0, 3);
    // tie out of reset: port0 then port1 write
    reset_dut();
    mem_lat = 1;
    mem_data = 32'h11111111;
    mem_q.push_back('{1'b1, 1'b0, 32'h10, 32'h0});
    mem_q.push_back('{1'b0, 1'b1, 32'h20, 32'h55});
    exp_q.push_back('{1'b0, 1'b0, 32'h11111111});
    exp_q.push_back('{1'b1, 1'b0, 32'h0});
    req(0, 1, 0, 32'h10, 32'h0);
    req(1, 0, 1, 32'h20, 32'h55);
    wait_rdy(0, 2);
    wait_rdy(1, 2);
    // second tie after port1 was last served: port0 first again
    mem_data = 32'hA5A5A5A5;
    mem_q.push_back('{1'b1, 1'b0, 32'h50, 32'h0});
    mem_q.push_back('{1'b1, 1'b0, 32'h60, 32'h0});
    exp_q.push_back('{1'b0, 1'b0, 32'hA5A5A5A5});
    exp_q.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
    req(0, 1, 0, 32'h50, 32'h0);
    req(1, 1, 0, 32'h60, 32'h0);
    wait_rdy(0, 2);
    mem_data = 32'hCAFEF00D;
    wait_rdy(1, 2);
    // rd+wr together is a write; rdata1 untouched
    mem_q.push_back('{1'b0, 1'b1, 32'h30, 32'h77});
    exp_q.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
    req(1, 1, 1, 32'h30, 32'h77);
    wait_rdy(1, 2);
    // NOP: ack without a memory cycle
    exp_q.push_back('{1'b0, 1'b0, 32'hA5A5A5A5});
    req(0, 0, 0, 32'h99, 32'h0);
    wait_rdy(0, 1);
    chk("nop_busy_after", 64'(bus.busy), 64'(0));
    // reset mid-BUSY, then a late mem_ready in IDLE
    mem_lat = 0;
    mem_q.push_back('{1'b1, 1'b0, 32'h300, 32'h0});
    req(0, 1, 0, 32'h300, 32'h0);
    tick(2);
    chk("t5_busy_before_rst", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    tick(1);
    chk("t5_mem_access_after_rst", 64'(bus.mem_access), 64'(0));
    chk("t5_busy_after_rst", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    bus.acc0 = 1'b0;
    kick = 1'b1;
    tick(1);
    kick = 1'b0;
    tick(3);
    chk("t5_busy_late_ready", 64'(bus.busy), 64'(0));
    chk("t5_mem_access_late_ready", 64'(bus.mem_access), 64'(0));
    chk("t5_rdata0", 64'(bus.rdata0), 64'(0));
`ifdef MEM_ARB_TIMEOUT_EN
    mem_lat = 4;
    mem_data = 32'h600DF00D;
    mem_q.push_back('{1'b1, 1'b0, 32'h210, 32'h0});
    exp_q.push_back('{1'b0, 1'b0, 32'h600DF00D});
    req(0, 1, 0, 32'h210, 32'h0);
    wait_rdy(0, 5);
    mem_lat = 0;
    mem_q.push_back('{1'b1, 1'b0, 32'h220, 32'h0});
    exp_q.push_back('{1'b0, 1'b1, 32'h600DF00D});
    req(0, 1, 0, 32'h220, 32'h0);
    wait_rdy(0, 5);
    chk("tmo_mem_access", 64'(bus.mem_access), 64'(0));
`else
    mem_q.push_back('{1'b1, 1'b0, 32'h200, 32'h0});
    req(0, 1, 0, 32'h200, 32'h0);
    tick(20);
    chk("hang_busy", 64'(bus.busy), 64'(1));
    chk("hang_mem_access", 64'(bus.mem_access), 64'(1));
    reset_dut();
    chk("hang_busy_after_rst", 64'(bus.busy), 64'(0));
`endif
    tick(3);
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    chk("mem_q_empty", 64'(mem_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
